skid_buffer: RTL and testbench

- Two-entry, first-word-fall-through buffer with full/empty flow control.
- Sits between a producer and a consumer to break the combinational ready/valid timing path.
- With one entry occupied, it sustains one transfer per cycle: simultaneous write and read every cycle.
- All outputs are driven from registers; there is no combinational path from any input to any output.

---
 rtl/skid_buffer.sv | 121 ++++++++++++
 tb/tb_skid_buffer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/skid_buffer.sv
// ---------------------------------------------------------------------------
// skid_buffer
//
// Two-entry first-word-fall-through buffer placed between a producer and a
// consumer. Its outputs come straight from flops, so it breaks the
// combinational ready/valid path between the two sides. With one entry held
// it can accept a write and serve a read on every edge.
//
// Ports:
//   clock        rising-edge clock
//   resetn       asynchronous active-low reset; clears all contents
//   write_enable push write_data at the rising edge (ignored while full)
//   write_data   data to push
//   full         two entries held; no write is accepted
//   read_enable  pop the head entry at the rising edge (ignored while empty)
//   read_data    head (oldest) entry; valid whenever empty is low
//   empty        no entries held
// ---------------------------------------------------------------------------
module skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             write_enable,
    input  logic [WIDTH-1:0] write_data,
    output logic             full,
    input  logic             read_enable,
    output logic [WIDTH-1:0] read_data,
    output logic             empty
);

    // Occupancy is tracked as a small state machine: 0, 1 or 2 entries.
    typedef enum logic [1:0] {
        OCC_ZERO = 2'd0,
        OCC_ONE  = 2'd1,
        OCC_TWO  = 2'd2
    } occ_t;

    occ_t             occ_q, occ_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            occ_q   <= OCC_ZERO;
            head_q  <= '0;
            skid_q  <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        skid_d = skid_q;

        case (occ_q)
            // Nothing to pop, so a read is ignored; a write lands in the head
            // and becomes visible right after this edge.
            OCC_ZERO: begin
                if (write_enable) begin
                    head_d = write_data;
                    occ_d  = OCC_ONE;
                end
            end

            // Streaming case: a simultaneous write and read replaces the head
            // directly and the skid register stays unused.
            OCC_ONE: begin
                case ({write_enable, read_enable})
                    2'b10: begin
                        skid_d = write_data;
                        occ_d  = OCC_TWO;
                    end
                    2'b01: begin
                        occ_d = OCC_ZERO;
                    end
                    2'b11: begin
                        head_d = write_data;
                    end
                    default: begin
                        occ_d = OCC_ONE;
                    end
                endcase
            end

            // Writes are dropped while full; a read moves the skid entry up.
            OCC_TWO: begin
                if (read_enable) begin
                    head_d = skid_q;
                    occ_d  = OCC_ONE;
                end
            end

            default: begin
                occ_d = OCC_ZERO;
            end
        endcase
    end

    // Flags are registered alongside the occupancy so they change on the same
    // edge and never depend on the enables combinationally.
    always_comb begin
        empty_d = (occ_d == OCC_ZERO);
        full_d  = (occ_d == OCC_TWO);
    end

    assign read_data = head_q;
    assign empty     = empty_q;
    assign full      = full_q;

endmodule

// File: tb/tb_skid_buffer.sv
// ---------------------------------------------------------------------------
// tb_skid_buffer
//
// Directed and scoreboarded random bench for skid_buffer. Inputs are driven
// 1 ns after each rising edge and outputs are sampled there as well, well
// away from the active edge.
// ---------------------------------------------------------------------------
module tb_skid_buffer;

    localparam int WIDTH = 8;

    logic             clock;
    logic             resetn;
    logic             write_enable;
    logic [WIDTH-1:0] write_data;
    logic             full;
    logic             read_enable;
    logic [WIDTH-1:0] read_data;
    logic             empty;

    int checks_total;
    int checks_passed;

    logic [WIDTH-1:0] model_q[$];

    skid_buffer #(.WIDTH(WIDTH)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .write_enable(write_enable),
        .write_data  (write_data),
        .full        (full),
        .read_enable (read_enable),
        .read_data   (read_data),
        .empty       (empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Counts one comparison and reports it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_total++;
        if (observed === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, lets the edge happen, then idles the inputs.
    task automatic applyStimulus(input logic we, input logic [WIDTH-1:0] wd,
                                 input logic re);
        write_enable = we;
        write_data   = wd;
        read_enable  = re;
        @(posedge clock);
        #1;
        write_enable = 1'b0;
        write_data   = '0;
        read_enable  = 1'b0;
    endtask

    task automatic checkFlags(input string tag, input logic exp_empty,
                              input logic exp_full);
        checkOutput({tag, "_empty"}, {31'd0, empty}, {31'd0, exp_empty});
        checkOutput({tag, "_full"},  {31'd0, full},  {31'd0, exp_full});
    endtask

    task automatic checkData(input string tag, input logic [WIDTH-1:0] exp_data);
        checkOutput({tag, "_data"}, {24'd0, read_data}, {24'd0, exp_data});
    endtask

    initial begin
        int cycles;
        int writes;
        logic we;
        logic re;
        logic [WIDTH-1:0] wd;

        checks_total  = 0;
        checks_passed = 0;
        resetn        = 1'b0;
        write_enable  = 1'b0;
        write_data    = '0;
        read_enable   = 1'b0;

        // Reset then idle.
        #23;
        checkFlags("in_reset", 1'b1, 1'b0);
        checkData("in_reset", 8'h00);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkFlags("idle", 1'b1, 1'b0);
        checkData("idle", 8'h00);

        // Fill with 0xAA then 0x55.
        applyStimulus(1'b1, 8'hAA, 1'b0);
        checkFlags("wr1", 1'b0, 1'b0);
        checkData("wr1", 8'hAA);
        applyStimulus(1'b1, 8'h55, 1'b0);
        checkFlags("wr2", 1'b0, 1'b1);
        checkData("wr2", 8'hAA);

        // Drain with two separate pops.
        checkData("pop1_value", 8'hAA);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkFlags("pop1", 1'b0, 1'b0);
        checkData("pop1", 8'h55);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkData("pop2_value", 8'h55);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkFlags("pop2", 1'b1, 1'b0);

        // Read while empty is ignored.
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkFlags("rd_empty", 1'b1, 1'b0);

        // Write and read together while empty: no pass-through, the word stays.
        applyStimulus(1'b1, 8'h77, 1'b1);
        checkFlags("wr_rd_empty", 1'b0, 1'b0);
        checkData("wr_rd_empty", 8'h77);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkFlags("wr_rd_empty_pop", 1'b1, 1'b0);

        // Throughput: one write per cycle, reads start one cycle later.
        applyStimulus(1'b1, 8'd0, 1'b0);
        checkFlags("stream_start", 1'b0, 1'b0);
        for (int i = 1; i <= 98; i++) begin
            checkData("stream_order", i[WIDTH-1:0] - 8'd1);
            applyStimulus(1'b1, i[WIDTH-1:0], 1'b1);
            checkFlags("stream", 1'b0, 1'b0);
        end
        checkData("stream_last", 8'd98);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkFlags("stream_end", 1'b1, 1'b0);

        // Write while full is dropped.
        applyStimulus(1'b1, 8'h11, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0);
        checkFlags("fill", 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h33, 1'b0);
        checkFlags("wr_full", 1'b0, 1'b1);
        checkData("wr_full", 8'h11);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkData("drop_pop1", 8'h22);
        checkFlags("drop_pop1", 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkFlags("drop_pop2", 1'b1, 1'b0);

        // Full with write and read together: read pops, write is dropped.
        applyStimulus(1'b1, 8'h44, 1'b0);
        applyStimulus(1'b1, 8'h66, 1'b0);
        applyStimulus(1'b1, 8'h99, 1'b1);
        checkFlags("full_wr_rd", 1'b0, 1'b0);
        checkData("full_wr_rd", 8'h66);

        // Reset mid-operation discards contents asynchronously.
        applyStimulus(1'b1, 8'h5A, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        checkFlags("mid_reset", 1'b1, 1'b0);
        checkData("mid_reset", 8'h00);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        checkFlags("after_reset", 1'b1, 1'b0);

        // Random traffic against a queue model.
        model_q.delete();
        writes = 0;
        cycles = 0;
        while (writes < 100 && cycles < 1000) begin
            we = ($urandom_range(0, 1) == 1) && (model_q.size() < 2);
            re = ($urandom_range(0, 1) == 1) && (model_q.size() > 0);
            wd = WIDTH'($urandom_range(0, 255));
            checkFlags("rand", model_q.size() == 0, model_q.size() == 2);
            if (re) begin
                checkData("rand_read", model_q[0]);
                void'(model_q.pop_front());
            end
            if (we) begin
                model_q.push_back(wd);
                writes++;
            end
            applyStimulus(we, wd, re);
            cycles++;
        end
        checkOutput("rand_write_budget", {31'd0, writes == 100}, 32'd1);

        cycles = 0;
        while (model_q.size() > 0 && cycles < 1000) begin
            checkData("drain_read", model_q[0]);
            void'(model_q.pop_front());
            applyStimulus(1'b0, 8'h00, 1'b1);
            cycles++;
        end
        checkOutput("drain_budget", {31'd0, model_q.size() == 0}, 32'd1);
        checkFlags("drain_end", 1'b1, 1'b0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
